instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 30 +++
 rtl/instr_fetch.sv | 114 +++++++++++
 tb/tb_instr_fetch.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction memory port plus controller-facing
// fetch/branch status, seen from the fetch side (master).
interface instr_fetch_if #(
  parameter int ADDR_W = 12
);
  logic              enablePC;
  logic              zeroFlag;
  logic              carryFlag;
  logic [ADDR_W-1:0] imemAddr;
  logic [18:0]       imemData;
  logic [18:0]       allBits;
  logic [ADDR_W-1:0] pc;
  logic              valid;
  logic              stackOverflow;
  logic              stackUnderflow;

  modport master (
    input  enablePC, zeroFlag, carryFlag,
    input  imemData,
    output imemAddr, allBits, pc, valid,
    output stackOverflow, stackUnderflow
  );

  modport slave (
    output enablePC, zeroFlag, carryFlag,
    output imemData,
    input  imemAddr, allBits, pc, valid,
    input  stackOverflow, stackUnderflow
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC sequencing, jumps, flag branches and a
// return-address stack with sticky overflow/underflow flags.
module instr_fetch #(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);
  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] nextPc;
  logic [ADDR_W-1:0] seqPc;
  logic [ADDR_W-1:0] target;
  logic [18:0]       allBits;
  logic              valid;
  logic              ovf;
  logic              unf;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] stackMem [STACK_DEPTH];
  logic [IW-1:0]     pushIdx;
  logic [IW-1:0]     topIdx;
  logic [2:0]        subOp;
  logic              isCtl;
  logic              isJmp;
  logic              isBz;
  logic              isBc;
  logic              isJsb;
  logic              isRet;
  logic              full;
  logic              empty;
  logic              doPush;
  logic              doPop;
  logic              setOvf;
  logic              setUnf;
  logic              advance;

  assign advance = !rst && bus.enablePC;
  assign seqPc   = pc + ADDR_W'(1);
  assign target  = bus.imemData[ADDR_W-1:0];
  assign subOp   = bus.imemData[16:14];
  assign isCtl   = bus.imemData[18:17] == 2'b11;
  assign isJmp   = isCtl && subOp == 3'b000;
  assign isBz    = isCtl && subOp == 3'b001;
  assign isBc    = isCtl && subOp == 3'b010;
  assign isJsb   = isCtl && subOp == 3'b100;
  assign isRet   = isCtl && subOp == 3'b101;

  assign full    = count == CW'(STACK_DEPTH);
  assign empty   = count == '0;
  assign pushIdx = IW'(count);
  assign topIdx  = IW'(count - CW'(1));

  always_comb begin
    nextPc = seqPc;
    doPush = 1'b0;
    doPop  = 1'b0;
    setOvf = 1'b0;
    setUnf = 1'b0;
    unique case (1'b1)
      isJmp: nextPc = target;
      isBz: if (bus.zeroFlag) nextPc = target;
      isBc: if (bus.carryFlag) nextPc = target;
      isJsb: begin
        nextPc = target;
        if (full) setOvf = 1'b1;
        else      doPush = 1'b1;
      end
      isRet: begin
        // Empty-stack return falls through sequentially.
        if (empty) begin
          setUnf = 1'b1;
        end else begin
          doPop  = 1'b1;
          nextPc = stackMem[topIdx];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      allBits <= '0;
      valid   <= 1'b0;
      count   <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else if (bus.enablePC) begin
      pc      <= nextPc;
      allBits <= bus.imemData;
      valid   <= 1'b1;
      if (doPush)     count <= count + CW'(1);
      else if (doPop) count <= count - CW'(1);
      if (setOvf) ovf <= 1'b1;
      if (setUnf) unf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (advance && doPush) stackMem[pushIdx] <= seqPc;
  end

  assign bus.imemAddr       = pc;
  assign bus.pc             = pc;
  assign bus.allBits        = allBits;
  assign bus.valid          = valid;
  assign bus.stackOverflow  = ovf;
  assign bus.stackUnderflow = unf;
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: vector table, directed
// stack/reset sequences, and randomized run against a queue model.
module tb_instr_fetch;
  localparam int AW    = 12;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(AW)) bus ();

  instr_fetch #(
    .ADDR_W(AW),
    .STACK_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] mPc;
  logic [18:0]   mAll;
  logic          mValid;
  logic          mOvf;
  logic          mUnf;
  logic [AW-1:0] mStack [$];

  typedef struct {
    logic          en;
    logic [18:0]   w;
    logic          zf;
    logic          cf;
    logic [AW-1:0] pc;
    logic [18:0]   ab;
    logic          ovf;
    logic          unf;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] ctl(input logic [2:0] op,
                                      input logic [AW-1:0] t);
    return {2'b11, op, 2'b00, t};
  endfunction

  function automatic vec_t mk(input logic en, input logic [18:0] w,
                              input logic zf, input logic cf,
                              input logic [AW-1:0] pc,
                              input logic [18:0] ab,
                              input logic ovf, input logic unf);
    vec_t v;
    v.en = en; v.w = w; v.zf = zf; v.cf = cf;
    v.pc = pc; v.ab = ab; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  // Reference behaviour: architectural rules applied to a queue stack.
  task automatic modelStep(input logic r, input logic en,
                           input logic [18:0] w,
                           input logic zf, input logic cf);
    logic [AW-1:0] seq;
    logic [AW-1:0] nxt;
    if (r) begin
      mPc = '0; mAll = '0; mValid = 1'b0;
      mOvf = 1'b0; mUnf = 1'b0;
      mStack.delete();
    end else if (en) begin
      seq = mPc + 1'b1;
      nxt = seq;
      if (w[18:17] == 2'b11) begin
        case (w[16:14])
          3'd0: nxt = w[AW-1:0];
          3'd1: if (zf) nxt = w[AW-1:0];
          3'd2: if (cf) nxt = w[AW-1:0];
          3'd4: begin
            if (mStack.size() < DEPTH) mStack.push_back(seq);
            else mOvf = 1'b1;
            nxt = w[AW-1:0];
          end
          3'd5: begin
            if (mStack.size() > 0) nxt = mStack.pop_back();
            else mUnf = 1'b1;
          end
          default: ;
        endcase
      end
      mAll = w; mValid = 1'b1; mPc = nxt;
    end
  endtask

  task automatic step(input logic r, input logic en,
                      input logic [18:0] w,
                      input logic zf, input logic cf);
    rst = r;
    bus.enablePC  = en;
    bus.imemData  = w;
    bus.zeroFlag  = zf;
    bus.carryFlag = cf;
    modelStep(r, en, w, zf, cf);
    @(posedge clk);
    #1;
  endtask

  task automatic chkState(input string name, input logic [AW-1:0] pc,
                          input logic [18:0] ab, input logic v,
                          input logic ovf, input logic unf);
    chk({name, ".pc"}, 64'(bus.pc), 64'(pc));
    chk({name, ".imemAddr"}, 64'(bus.imemAddr), 64'(pc));
    chk({name, ".allBits"}, 64'(bus.allBits), 64'(ab));
    chk({name, ".valid"}, 64'(bus.valid), 64'(v));
    chk({name, ".ovf"}, 64'(bus.stackOverflow), 64'(ovf));
    chk({name, ".unf"}, 64'(bus.stackUnderflow), 64'(unf));
  endtask

  initial begin
    logic [AW-1:0] tgt [9];
    logic [AW-1:0] ret [9];
    logic [18:0]   w;
    logic [2:0]    op;
    logic [AW-1:0] holdPc;
    logic [18:0]   holdAb;
    logic          r;
    logic          en;

    rst = 1'b1;
    bus.enablePC  = 1'b0;
    bus.imemData  = '0;
    bus.zeroFlag  = 1'b0;
    bus.carryFlag = 1'b0;

    step(1'b1, 1'b0, 19'h7FFFF, 1'b1, 1'b1);
    chkState("reset", '0, '0, 1'b0, 1'b0, 1'b0);

    tbl.push_back(mk(1, 19'h00001, 0, 0, 12'h001, 19'h00001, 0, 0));
    tbl.push_back(mk(1, 19'h12345, 0, 0, 12'h002, 19'h12345, 0, 0));
    tbl.push_back(mk(1, 19'h0ABCD, 0, 0, 12'h003, 19'h0ABCD, 0, 0));
    tbl.push_back(mk(1, ctl(0, 12'h010), 0, 0, 12'h010, ctl(0, 12'h010), 0, 0));
    tbl.push_back(mk(1, ctl(0, 12'h050), 1, 1, 12'h050, ctl(0, 12'h050), 0, 0));
    tbl.push_back(mk(1, ctl(1, 12'h020), 0, 1, 12'h051, ctl(1, 12'h020), 0, 0));
    tbl.push_back(mk(1, ctl(1, 12'h020), 1, 0, 12'h020, ctl(1, 12'h020), 0, 0));
    tbl.push_back(mk(1, ctl(2, 12'h030), 1, 0, 12'h021, ctl(2, 12'h030), 0, 0));
    tbl.push_back(mk(1, ctl(2, 12'h030), 0, 1, 12'h030, ctl(2, 12'h030), 0, 0));
    tbl.push_back(mk(1, ctl(3, 12'h777), 1, 1, 12'h031, ctl(3, 12'h777), 0, 0));
    tbl.push_back(mk(0, ctl(0, 12'h123), 1, 1, 12'h031, ctl(3, 12'h777), 0, 0));
    tbl.push_back(mk(1, ctl(0, 12'h040), 0, 0, 12'h040, ctl(0, 12'h040), 0, 0));
    tbl.push_back(mk(1, ctl(4, 12'h100), 0, 0, 12'h100, ctl(4, 12'h100), 0, 0));
    tbl.push_back(mk(1, ctl(5, 12'h000), 0, 0, 12'h041, ctl(5, 12'h000), 0, 0));
    tbl.push_back(mk(1, ctl(5, 12'h000), 0, 0, 12'h042, ctl(5, 12'h000), 0, 1));
    tbl.push_back(mk(1, ctl(0, 12'hFFF), 0, 0, 12'hFFF, ctl(0, 12'hFFF), 0, 1));
    tbl.push_back(mk(1, 19'h2AAAA, 1, 1, 12'h000, 19'h2AAAA, 0, 1));
    tbl.push_back(mk(1, ctl(6, 12'h321), 1, 1, 12'h001, ctl(6, 12'h321), 0, 1));
    tbl.push_back(mk(1, ctl(7, 12'h321), 1, 1, 12'h002, ctl(7, 12'h321), 0, 1));
    tbl.push_back(mk(1, 19'h55555, 1, 1, 12'h003, 19'h55555, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b0, tbl[i].en, tbl[i].w, tbl[i].zf, tbl[i].cf);
      chkState($sformatf("vec%0d", i), tbl[i].pc, tbl[i].ab, 1'b1,
               tbl[i].ovf, tbl[i].unf);
    end

    // Nine nested calls then nine returns.
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tgt[i] = AW'((i + 1) * 256);
      ret[i] = (i == 0) ? 12'h001 : tgt[i-1] + 1'b1;
      step(1'b0, 1'b1, ctl(4, tgt[i]), 1'b0, 1'b0);
      chkState($sformatf("jsb%0d", i), tgt[i], ctl(4, tgt[i]), 1'b1,
               i == 8, 1'b0);
    end
    for (int j = 0; j < 9; j++) begin
      step(1'b0, 1'b1, ctl(5, 12'hABC), 1'b1, 1'b1);
      chkState($sformatf("ret%0d", j),
               (j < 8) ? ret[7-j] : ret[0] + 1'b1,
               ctl(5, 12'hABC), 1'b1, 1'b1, j == 8);
    end

    // Hold with enable low, then resume.
    holdPc = bus.pc;
    holdAb = bus.allBits;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, ctl(0, AW'($urandom())), 1'b1, 1'b1);
      chkState($sformatf("hold%0d", k), holdPc, holdAb, 1'b1, 1'b1, 1'b1);
    end
    step(1'b0, 1'b1, 19'h00123, 1'b0, 1'b0);
    chkState("resume", holdPc + 1'b1, 19'h00123, 1'b1, 1'b1, 1'b1);

    // Reset with live stack entries, then return on an empty stack.
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, ctl(4, 12'h100), 1'b0, 1'b0);
    step(1'b0, 1'b1, ctl(4, 12'h200), 1'b0, 1'b0);
    step(1'b0, 1'b1, ctl(4, 12'h300), 1'b0, 1'b0);
    chkState("pre_rst", 12'h300, ctl(4, 12'h300), 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, ctl(0, 12'h555), 1'b1, 1'b1);
    chkState("mid_rst", 12'h000, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, ctl(5, 12'h000), 1'b0, 1'b0);
    chkState("rst_ret", 12'h001, ctl(5, 12'h000), 1'b1, 1'b0, 1'b1);

    // Randomized run against the reference model.
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 7))
          0, 1, 2: op = 3'd4;
          3, 4:    op = 3'd5;
          default: op = 3'($urandom());
        endcase
        w = ctl(op, AW'($urandom()));
      end else begin
        w = 19'($urandom());
      end
      step(r, en, w, 1'($urandom()), 1'($urandom()));
      chk($sformatf("rand%0d", n),
          {18'b0, bus.pc, bus.imemAddr, bus.allBits, bus.valid,
           bus.stackOverflow, bus.stackUnderflow},
          {18'b0, mPc, mPc, mAll, mValid, mOvf, mUnf});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
